sr_run_ctrl: RTL and testbench

Run controller for the schoolRISCV core. It loads a program into instruction memory through a valid/ready port, and holds the CPU in reset while loading. It then releases the CPU, gates its state updates, and halts it on stop, breakpoint or `noop` (unsupported instruction). It also supports single-stepping and continuing. It sits beside `sr_cpu` in the integration top, owns the imem write port, and drives the core's synchronous active-high reset plus a cycle-enable that the top applies to the pc register and the register-file write enable.

---
 rtl/sr_run_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sr_run_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sr_run_ctrl
// Description : Run controller for the schoolRISCV core: program loader,
//               CPU reset/enable sequencing, halt, single-step and continue.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_run_ctrl #(
    parameter int IMEM_AW = 6,
    parameter int CYCLE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [IMEM_AW-1:0] ld_addr,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               cont,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        pc,
    input  logic               noop,
    output logic               cpu_rst,
    output logic               cpu_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [CYCLE_W-1:0] cycle_cnt
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_RESET = 3'd2;
    localparam logic [2:0] c_RUN   = 3'd3;
    localparam logic [2:0] c_STEP  = 3'd4;
    localparam logic [2:0] c_HALT  = 3'd5;

    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_STOP = 2'd1;
    localparam logic [1:0] c_CAUSE_BP   = 2'd2;
    localparam logic [1:0] c_CAUSE_NOOP = 2'd3;

    localparam logic [CYCLE_W-1:0] c_CNT_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_state;
    logic               r_rstPhase;
    logic               r_afterCont;
    logic [1:0]         r_haltCause;
    logic [CYCLE_W-1:0] r_cycleCnt;
    logic               r_imemWe;
    logic [IMEM_AW-1:0] r_imemWaddr;
    logic [31:0]        r_imemWdata;

    logic       w_inLoader;
    logic       w_isRun;
    logic       w_isHalt;
    logic       w_ldFire;
    logic       w_startOk;
    logic       w_bpHit;
    logic       w_haltDet;
    logic [1:0] w_detCause;

    assign w_inLoader = (r_state == c_IDLE) || (r_state == c_LOAD);
    assign w_isRun    = (r_state == c_RUN);
    assign w_isHalt   = (r_state == c_HALT);
    assign w_ldFire   = ld_valid && ld_ready;
    assign w_startOk  = start && (w_inLoader || w_isHalt);

    // The instruction just resumed from may itself be the breakpoint.
    assign w_bpHit = bp_en && (pc == bp_addr) && !r_afterCont;

    always_comb begin
        w_detCause = c_CAUSE_NONE;
        if (stop) begin
            w_detCause = c_CAUSE_STOP;
        end else if (w_bpHit) begin
            w_detCause = c_CAUSE_BP;
        end else if (noop) begin
            w_detCause = c_CAUSE_NOOP;
        end
    end

    assign w_haltDet = w_isRun && (w_detCause != c_CAUSE_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_rstPhase  <= 1'b0;
            r_afterCont <= 1'b0;
        end else begin
            r_afterCont <= 1'b0;
            case (r_state)
                c_IDLE, c_LOAD: begin
                    if (start) begin
                        r_state <= c_RESET;
                    end else if (w_ldFire) begin
                        r_state <= ld_last ? c_IDLE : c_LOAD;
                    end
                end
                c_RESET: begin
                    r_rstPhase <= ~r_rstPhase;
                    if (r_rstPhase) begin
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_haltDet) begin
                        r_state <= c_HALT;
                    end
                end
                c_STEP: r_state <= c_HALT;
                c_HALT: begin
                    if (start) begin
                        r_state <= c_RESET;
                    end else if (cont) begin
                        r_state     <= c_RUN;
                        r_afterCont <= 1'b1;
                    end else if (step) begin
                        r_state <= c_STEP;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_haltCause <= c_CAUSE_NONE;
            r_cycleCnt  <= '0;
        end else begin
            if (w_startOk) begin
                r_haltCause <= c_CAUSE_NONE;
            end else if (w_haltDet) begin
                r_haltCause <= w_detCause;
            end else if (w_isHalt && !cont && step) begin
                r_haltCause <= c_CAUSE_NONE;
            end

            if (w_startOk) begin
                r_cycleCnt <= '0;
            end else if (cpu_en && !(&r_cycleCnt)) begin
                r_cycleCnt <= r_cycleCnt + c_CNT_ONE;
            end
        end
    end

    // Write port trails the handshake by one cycle, even past ld_last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_imemWe    <= 1'b0;
            r_imemWaddr <= '0;
            r_imemWdata <= '0;
        end else begin
            r_imemWe <= w_ldFire;
            if (w_ldFire) begin
                r_imemWaddr <= ld_addr;
                r_imemWdata <= ld_data;
            end
        end
    end

    assign ld_ready   = w_inLoader && !start;
    assign cpu_rst    = w_inLoader || (r_state == c_RESET);
    assign cpu_en     = (w_isRun && !w_haltDet) || (r_state == c_STEP);
    assign busy       = (r_state == c_RESET) || w_isRun || (r_state == c_STEP);
    assign halted     = w_isHalt;
    assign halt_cause = r_haltCause;
    assign cycle_cnt  = r_cycleCnt;
    assign imem_we    = r_imemWe;
    assign imem_waddr = r_imemWaddr;
    assign imem_wdata = r_imemWdata;

endmodule
`default_nettype wire

// File: tb/tb_sr_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_run_ctrl
// Description : Self-checking bench for sr_run_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_run_ctrl;

    localparam int AW = 6;
    localparam int CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, ld_last;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          start, stop, step, cont, bp_en, noop;
    logic [31:0]   bp_addr, pc;
    logic          cpu_rst, cpu_en, imem_we, busy, halted;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cycle_cnt;

    always #5 clk = ~clk;

    sr_run_ctrl #(.IMEM_AW(AW), .CYCLE_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last),
        .start(start), .stop(stop), .step(step), .cont(cont),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .noop(noop),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .busy(busy), .halted(halted), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt)
    );

    // Minimal stand-in for the core: pc advances one word per enabled cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst)         pc <= 32'h0;
        else if (cpu_rst) pc <= 32'h0;
        else if (cpu_en)  pc <= pc + 32'd4;
    end

    int total = 0;
    int bad = 0;
    int enPulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: controller described by mode plus a few counters.
    typedef enum int {M_IDLE, M_LOAD, M_RST, M_RUN, M_STEP, M_HALT} mode_e;
    mode_e       mMode;
    int          mRstLeft;
    bit          mJustCont;
    int          mCause;
    int          mCnt;
    bit          mWe;
    logic [AW-1:0] mWaddr;
    logic [31:0] mWdata;

    task automatic modelReset();
        mMode = M_IDLE; mRstLeft = 0; mJustCont = 0; mCause = 0; mCnt = 0;
        mWe = 0; mWaddr = '0; mWdata = '0;
    endtask

    function automatic int mDetect();
        if (mMode != M_RUN) return 0;
        if (stop) return 1;
        if (bp_en && pc == bp_addr && !mJustCont) return 2;
        if (noop) return 3;
        return 0;
    endfunction

    task automatic enterReset();
        mMode = M_RST; mRstLeft = 2; mCnt = 0; mCause = 0;
    endtask

    task automatic modelCheckUpdate();
        int det;
        bit expReady, expEn, fire, nextJust;
        det      = mDetect();
        expReady = (mMode == M_IDLE || mMode == M_LOAD) && !start;
        expEn    = (mMode == M_RUN && det == 0) || mMode == M_STEP;
        chk("ld_ready", ld_ready, expReady);
        chk("cpu_rst", cpu_rst, mMode == M_IDLE || mMode == M_LOAD || mMode == M_RST);
        chk("cpu_en", cpu_en, expEn);
        chk("busy", busy, mMode == M_RST || mMode == M_RUN || mMode == M_STEP);
        chk("halted", halted, mMode == M_HALT);
        chk("halt_cause", halt_cause, mCause);
        chk("cycle_cnt", cycle_cnt, mCnt);
        chk("imem_we", imem_we, mWe);
        if (mWe) begin
            chk("imem_waddr", imem_waddr, mWaddr);
            chk("imem_wdata", imem_wdata, mWdata);
        end
        if (cpu_en) enPulses++;

        fire = ld_valid && expReady;
        mWe = fire;
        if (fire) begin mWaddr = ld_addr; mWdata = ld_data; end
        if (expEn && mCnt < CNT_MAX) mCnt++;
        nextJust = 0;
        case (mMode)
            M_IDLE, M_LOAD: begin
                if (start) enterReset();
                else if (fire) mMode = ld_last ? M_IDLE : M_LOAD;
            end
            M_RST: begin
                mRstLeft--;
                if (mRstLeft == 0) mMode = M_RUN;
            end
            M_RUN: if (det != 0) begin mMode = M_HALT; mCause = det; end
            M_STEP: mMode = M_HALT;
            M_HALT: begin
                if (start) enterReset();
                else if (cont) begin mMode = M_RUN; nextJust = 1; end
                else if (step) begin mMode = M_STEP; mCause = 0; end
            end
            default: mMode = M_IDLE;
        endcase
        mJustCont = nextJust;
    endtask

    task automatic tick();
        @(negedge clk);
        modelCheckUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic runUntilHalt(input string name);
        for (int k = 0; k < 60 && !halted; k++) tick();
        chk(name, halted, 1'b1);
    endtask

    typedef struct {
        bit          v;
        logic [AW-1:0] a;
        logic [31:0] d;
        bit          last;
        bit          st;
        bit          eReady;
        bit          eWe;
        logic [AW-1:0] eAddr;
        logic [31:0] eData;
        bit          eRst;
        bit          eEn;
        bit          eBusy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 6'd0, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 6'd1, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 32'h0000_0013, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 6'd2, 32'h0020_0113, 1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 32'h0010_0093, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd2, 32'h0020_0113, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b1};

        rst = 1'b0;
        ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
        start = 0; stop = 0; step = 0; cont = 0; bp_en = 0; bp_addr = '0; noop = 0;
        modelReset();
        #12;
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_cpu_en", cpu_en, 1'b0);
        chk("rst_imem_we", imem_we, 1'b0);
        chk("rst_imem_waddr", imem_waddr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_ready", ld_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Load three words, then start.
        for (int i = 0; i < 9; i++) begin
            ld_valid = tbl[i].v; ld_addr = tbl[i].a; ld_data = tbl[i].d;
            ld_last = tbl[i].last; start = tbl[i].st;
            @(negedge clk);
            chk("tbl_ready", ld_ready, tbl[i].eReady);
            chk("tbl_we", imem_we, tbl[i].eWe);
            if (tbl[i].eWe) begin
                chk("tbl_waddr", imem_waddr, tbl[i].eAddr);
                chk("tbl_wdata", imem_wdata, tbl[i].eData);
            end
            chk("tbl_cpu_rst", cpu_rst, tbl[i].eRst);
            chk("tbl_cpu_en", cpu_en, tbl[i].eEn);
            chk("tbl_busy", busy, tbl[i].eBusy);
            modelCheckUpdate();
            @(posedge clk); #1;
        end
        ld_valid = 0; ld_last = 0; start = 0;

        // Ten RUN cycles in total, then stop.
        repeat (9) tick();
        stop = 1; tick(); stop = 0;
        chk("stop_cnt", cycle_cnt, 10);
        chk("stop_halted", halted, 1'b1);
        chk("stop_cause", halt_cause, 1);

        // Breakpoint at 0x10, then continue past it.
        bp_en = 1; bp_addr = 32'h10;
        start = 1; tick(); start = 0;
        for (int k = 0; k < 60 && !halted; k++) begin
            if (pc == 32'h10 && !cpu_rst) chk("bp_detect_en", cpu_en, 1'b0);
            tick();
        end
        chk("bp_halted", halted, 1'b1);
        chk("bp_pc", pc, 32'h10);
        chk("bp_cause", halt_cause, 2);
        cont = 1; tick(); cont = 0;
        repeat (3) tick();
        chk("cont_pc", pc, 32'h1C);
        chk("cont_running", halted, 1'b0);
        stop = 1; tick(); stop = 0;

        // Halt at 0x8, then two single steps.
        bp_addr = 32'h8;
        start = 1; tick(); start = 0;
        runUntilHalt("step_halt");
        chk("step_pc0", pc, 32'h8);
        enPulses = 0;
        repeat (2) begin
            step = 1; tick(); step = 0;
            tick(); tick();
        end
        chk("step_pulses", enPulses, 2);
        chk("step_cnt", cycle_cnt, 4);
        chk("step_cause", halt_cause, 0);
        chk("step_pc", pc, 32'h10);
        chk("step_halted", halted, 1'b1);

        // Halt cause priority: stop over noop, then noop alone.
        bp_en = 0;
        start = 1; tick(); start = 0;
        repeat (5) tick();
        stop = 1; noop = 1; tick(); stop = 0; noop = 0;
        chk("prio_cause", halt_cause, 1);
        start = 1; tick(); start = 0;
        repeat (5) tick();
        noop = 1; tick(); noop = 0;
        chk("noop_cause", halt_cause, 3);
        chk("noop_cnt", cycle_cnt, 3);
        chk("noop_halted", halted, 1'b1);

        // Counter saturation.
        start = 1; tick(); start = 0;
        repeat (75) tick();
        chk("sat_cnt", cycle_cnt, CNT_MAX);

        // Asynchronous reset while running.
        @(negedge clk); #2;
        rst = 1'b0; #1;
        chk("arst_cpu_rst", cpu_rst, 1'b1);
        chk("arst_cpu_en", cpu_en, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cnt", cycle_cnt, 0);
        chk("arst_ready", ld_ready, 1'b1);
        modelReset();
        @(posedge clk); #1; rst = 1'b1;

        // Pending write is dropped by reset.
        ld_valid = 1; ld_addr = 6'd5; ld_data = 32'hDEAD_BEEF; ld_last = 1;
        @(posedge clk); #2;
        ld_valid = 0; ld_last = 0; rst = 1'b0; #1;
        chk("drop_we", imem_we, 1'b0);
        chk("drop_waddr", imem_waddr, 0);
        modelReset();
        @(posedge clk); #1; rst = 1'b1;

        // start wins over ld_valid in IDLE.
        ld_valid = 1; ld_addr = 6'd7; ld_data = 32'h1234; start = 1;
        #1 chk("sv_ready", ld_ready, 1'b0);
        tick();
        ld_valid = 0; start = 0;
        chk("sv_busy", busy, 1'b1);
        chk("sv_cpu_rst", cpu_rst, 1'b1);
        chk("sv_we", imem_we, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            start    = ($urandom % 40) == 0;
            stop     = ($urandom % 25) == 0;
            step     = ($urandom % 6) == 0;
            cont     = ($urandom % 12) == 0;
            noop     = ($urandom % 30) == 0;
            if (($urandom % 20) == 0) begin
                bp_en   = $urandom % 2;
                bp_addr = 32'($urandom_range(0, 16)) * 32'd4;
            end
            ld_valid = $urandom % 2;
            ld_addr  = AW'($urandom);
            ld_data  = $urandom;
            ld_last  = ($urandom % 5) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
